synth_cfg_req_tx: RTL
=====================

# synth_cfg_req_tx

CPU-clock-domain initiator for the synth configuration transfer. It holds CPU-writable staging registers for carrier FCWs, modulator FCW/shift, note enables and synth shift. On a commit it snapshots them onto a bus that stays stable and runs a four-phase req/ack handshake with the synth-domain receiver. The block sits between the MMIO decoder and the CDC receiver; `cpu_ack` arrives already synchronized into `clk`.

## Interface
- `N_VOICES`, default 1: number of carrier voices, range 1..8.
- `clk` input 1: CPU clock; all logic on its rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `wr_en` input 1: MMIO write strobe, one write per cycle.
- `wr_addr` input 4: register word index.
- `wr_data` input 32: write data, low bits used.
- `rd_addr` input 4: read index.
- `rd_data` output 32: combinational read of staging/status.
- `cpu_carrier_fcws` output [N_VOICES-1:0][23:0]: snapshot carrier FCWs.
- `cpu_mod_fcw` output 24, `cpu_mod_shift` output 5, `cpu_note_en` output N_VOICES, `cpu_synth_shift` output 5: snapshot fields.
- `cpu_req` output 1: registered handshake request.
- `cpu_ack` input 1: synchronized acknowledge from the synth domain.
- `busy` output 1: handshake in progress (state ≠ IDLE).
- `done` output 1: one-cycle pulse when a transfer completes.
- `proto_err` output 1: sticky flag, set when `cpu_ack` rises in IDLE.

## Operation
- Address map: 0x0–0x7 carrier FCW voice i, `wr_data[23:0]`; indices ≥ N_VOICES are ignored on write and read 0. 0x8 mod_fcw [23:0]. 0x9 mod_shift [4:0]. 0xA note_en [N_VOICES-1:0]. 0xB synth_shift [4:0]. 0xC COMMIT, data ignored, reads 0. 0xD STATUS, read-only: {xfer_count[15:0], 12'b0, proto_err, pending, busy, cpu_req}. 0xE write of bit0=1 clears proto_err. 0xF is reserved.
- Staging writes are accepted in every state and never disturb the snapshot outputs.
- A COMMIT write sets `pending`. Multiple commits before launch coalesce into one transfer.
- FSM states:
  - IDLE: if `pending` and `cpu_ack`==0, copy staging into the snapshot outputs, set `cpu_req`=1, clear `pending`, and go to REQ. If `cpu_ack`==1, stay in IDLE and keep `pending`.
  - REQ: hold `cpu_req`=1. When `cpu_ack`==1, set `cpu_req`=0 and go to RELEASE.
  - RELEASE: hold `cpu_req`=0. When `cpu_ack`==0, go to IDLE, pulse `done`, and increment `xfer_count` (16-bit, wraps from 0xFFFF to 0).
- The snapshot outputs stay constant from launch until the next launch. They are never modified while `busy`.
- A COMMIT during REQ/RELEASE sets `pending`. The next transfer launches from the new staging contents no earlier than the cycle after returning to IDLE.
- A staging write and a launch in the same cycle: the snapshot takes the pre-write staging value.
- A COMMIT in the same cycle as a launch: `pending` ends at 1, because the set wins over the clear.
- There is no timeout; a stuck ack leaves the FSM waiting indefinitely.

## Timing
- Reset values, all 0: staging, snapshot outputs, `cpu_req`, `pending`, `busy`, `done`, `proto_err`, `xfer_count`. State is IDLE.
- Commit sampled at edge k gives `pending`=1 after k. Edge k+1 launches, giving `cpu_req`=1 and `busy`=1.
- `cpu_ack`=1 sampled at edge m gives `cpu_req`=0 after m.
- `cpu_ack`=0 sampled at edge p gives `done`=1 for the cycle after p and `busy`=0.
- Minimum back-to-back spacing is IDLE for one cycle between transfers.
- Reset mid-transfer clears `cpu_req` immediately. The IDLE launch guard then holds off any new request until the receiver's ack has dropped.

## Structure
- Package `synth_cfg_pkg`: address constants (ADDR_CARRIER0, ADDR_MOD_FCW, ADDR_MOD_SHIFT, ADDR_NOTE_EN, ADDR_SYNTH_SHIFT, ADDR_COMMIT, ADDR_STATUS, ADDR_ERRCLR), FSM state enum `hs_state_t`, and field widths FCW_W=24, SHIFT_W=5.
- Sub-module `req_ack_initiator`: the generic four-phase FSM with ports `start`, `ack`, `req`, `busy`, `done`, and `launch` (the snapshot-load strobe). The top level holds the register file, the snapshot registers and the counter.

## Test plan
- Reset, then read STATUS: returns 0. All snapshot outputs are 0. `cpu_req`=0.
- N_VOICES=2. Write voice0=0x123456, voice1=0x0ABCDE, note_en=0x3, then COMMIT. A model receiver acks 3 cycles after req and drops ack 3 cycles after req falls. Required: snapshot equals the staging values at launch, one `done` pulse, xfer_count=1.
- During REQ, write mod_fcw=0x000100 and COMMIT. Required: the snapshot stays at the old mod_fcw until the second launch, which occurs 1 cycle after IDLE is re-entered. Final xfer_count=2.
- Three COMMITs in IDLE with ack held high. Required: no req while ack=1. Exactly one transfer after ack drops. proto_err=1. Writing 0xE with bit0=1 clears proto_err.
- Assert `rst` while in REQ. Required: `cpu_req` drops that cycle, no launch while ack remains 1, and normal transfers afterwards.
- Preload xfer_count near wrap with 65536 transfers, or use force. Required: the counter reads 0x0000 after wrap. A write to voice index 5 with N_VOICES=2 is ignored and reads 0.

Source files
------------

// File: rtl/synth_cfg_pkg.sv
// Shared definitions for the synth configuration transfer initiator:
// MMIO word addresses, handshake FSM state encoding and field widths.
package synth_cfg_pkg;

  localparam int FCW_W   = 24;
  localparam int SHIFT_W = 5;

  localparam logic [3:0] ADDR_CARRIER0    = 4'h0;
  localparam logic [3:0] ADDR_MOD_FCW     = 4'h8;
  localparam logic [3:0] ADDR_MOD_SHIFT   = 4'h9;
  localparam logic [3:0] ADDR_NOTE_EN     = 4'hA;
  localparam logic [3:0] ADDR_SYNTH_SHIFT = 4'hB;
  localparam logic [3:0] ADDR_COMMIT      = 4'hC;
  localparam logic [3:0] ADDR_STATUS      = 4'hD;
  localparam logic [3:0] ADDR_ERRCLR      = 4'hE;

  typedef enum logic [1:0] {
    HS_IDLE    = 2'd0,
    HS_REQ     = 2'd1,
    HS_RELEASE = 2'd2
  } hs_state_t;

endpackage

// File: rtl/req_ack_initiator.sv
// Generic four-phase req/ack initiator.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   start     : a transfer is wanted (level, sampled in IDLE)
//   ack       : acknowledge from the receiver, already synchronized
//   req       : registered request to the receiver
//   busy      : a handshake is in progress (state != IDLE)
//   done      : one-cycle pulse after the handshake completes
//   launch    : combinational strobe, high in the cycle whose edge starts a
//               transfer; the owner loads its payload on that edge
module req_ack_initiator
  import synth_cfg_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic ack,
  output logic req,
  output logic busy,
  output logic done,
  output logic launch
);

  hs_state_t r_state;
  hs_state_t w_state_nxt;
  logic      r_req;
  logic      w_req_nxt;
  logic      r_done;
  logic      w_done_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= HS_IDLE;
      r_req   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_req   <= w_req_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req_nxt   = r_req;
    w_done_nxt  = 1'b0;
    launch      = 1'b0;
    case (r_state)
      HS_IDLE: begin
        // A lingering ack (e.g. after a reset mid-transfer) blocks launch
        // until the receiver has returned to zero.
        if (start && !ack) begin
          launch      = 1'b1;
          w_req_nxt   = 1'b1;
          w_state_nxt = HS_REQ;
        end
      end
      HS_REQ: begin
        w_req_nxt = 1'b1;
        if (ack) begin
          w_req_nxt   = 1'b0;
          w_state_nxt = HS_RELEASE;
        end
      end
      HS_RELEASE: begin
        w_req_nxt = 1'b0;
        if (!ack) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = HS_IDLE;
        end
      end
      default: begin
        w_req_nxt   = 1'b0;
        w_state_nxt = HS_IDLE;
      end
    endcase
  end

  assign req  = r_req;
  assign busy = (r_state != HS_IDLE);
  assign done = r_done;

endmodule

// File: rtl/synth_cfg_req_tx.sv
// CPU-domain initiator of the synth configuration transfer.
// Holds CPU-writable staging registers, snapshots them on launch onto a bus
// that stays stable for the receiver, and drives a four-phase handshake.
// Ports:
//   clk, rst          : CPU clock, asynchronous active-high reset
//   wr_en/addr/data   : MMIO write port (word index, low data bits used)
//   rd_addr, rd_data  : combinational MMIO read of staging/status
//   cpu_carrier_fcws, cpu_mod_fcw, cpu_mod_shift, cpu_note_en,
//   cpu_synth_shift   : snapshot bus towards the synth domain
//   cpu_req, cpu_ack  : handshake (ack already synchronized into clk)
//   busy, done        : handshake in progress / completion pulse
//   proto_err         : sticky, ack rose while no request was outstanding
module synth_cfg_req_tx
  import synth_cfg_pkg::*;
#(
  parameter int N_VOICES = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wr_en,
  input  logic [3:0]                       wr_addr,
  input  logic [31:0]                      wr_data,
  input  logic [3:0]                       rd_addr,
  output logic [31:0]                      rd_data,
  output logic [N_VOICES-1:0][FCW_W-1:0]   cpu_carrier_fcws,
  output logic [FCW_W-1:0]                 cpu_mod_fcw,
  output logic [SHIFT_W-1:0]               cpu_mod_shift,
  output logic [N_VOICES-1:0]              cpu_note_en,
  output logic [SHIFT_W-1:0]               cpu_synth_shift,
  output logic                             cpu_req,
  input  logic                             cpu_ack,
  output logic                             busy,
  output logic                             done,
  output logic                             proto_err
);

  logic [N_VOICES-1:0][FCW_W-1:0] r_stg_car;
  logic [FCW_W-1:0]               r_stg_mod_fcw;
  logic [SHIFT_W-1:0]             r_stg_mod_shift;
  logic [N_VOICES-1:0]            r_stg_note_en;
  logic [SHIFT_W-1:0]             r_stg_synth_shift;

  logic [N_VOICES-1:0][FCW_W-1:0] r_snap_car;
  logic [FCW_W-1:0]               r_snap_mod_fcw;
  logic [SHIFT_W-1:0]             r_snap_mod_shift;
  logic [N_VOICES-1:0]            r_snap_note_en;
  logic [SHIFT_W-1:0]             r_snap_synth_shift;

  logic        r_pending;
  logic        r_proto_err;
  logic        r_ack_d;
  logic [15:0] r_xfer_count;

  logic w_commit;
  logic w_errclr;
  logic w_launch;
  logic w_req;
  logic w_busy;
  logic w_done;
  logic w_complete;
  logic w_ack_rise_idle;
  logic w_unused_wr_data;

  assign w_commit         = wr_en && (wr_addr == ADDR_COMMIT);
  assign w_errclr         = wr_en && (wr_addr == ADDR_ERRCLR) && wr_data[0];
  // Busy with req low is the release phase; ack low there ends the transfer
  // on the same edge the FSM returns to IDLE.
  assign w_complete       = w_busy && !w_req && !cpu_ack;
  assign w_ack_rise_idle  = !w_busy && cpu_ack && !r_ack_d;
  assign w_unused_wr_data = &{1'b0, wr_data[31:FCW_W]};

  req_ack_initiator u_hs (
    .clk    (clk),
    .rst    (rst),
    .start  (r_pending),
    .ack    (cpu_ack),
    .req    (w_req),
    .busy   (w_busy),
    .done   (w_done),
    .launch (w_launch)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stg_car         <= '0;
      r_stg_mod_fcw     <= '0;
      r_stg_mod_shift   <= '0;
      r_stg_note_en     <= '0;
      r_stg_synth_shift <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < N_VOICES; i++) begin
        if (wr_addr == 4'(i)) r_stg_car[i] <= wr_data[FCW_W-1:0];
      end
      case (wr_addr)
        ADDR_MOD_FCW:     r_stg_mod_fcw     <= wr_data[FCW_W-1:0];
        ADDR_MOD_SHIFT:   r_stg_mod_shift   <= wr_data[SHIFT_W-1:0];
        ADDR_NOTE_EN:     r_stg_note_en     <= wr_data[N_VOICES-1:0];
        ADDR_SYNTH_SHIFT: r_stg_synth_shift <= wr_data[SHIFT_W-1:0];
        default: ;
      endcase
    end
  end

  // Snapshot loads from the registered staging values, so a write landing on
  // the launch edge is not part of this transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_snap_car         <= '0;
      r_snap_mod_fcw     <= '0;
      r_snap_mod_shift   <= '0;
      r_snap_note_en     <= '0;
      r_snap_synth_shift <= '0;
    end else if (w_launch) begin
      r_snap_car         <= r_stg_car;
      r_snap_mod_fcw     <= r_stg_mod_fcw;
      r_snap_mod_shift   <= r_stg_mod_shift;
      r_snap_note_en     <= r_stg_note_en;
      r_snap_synth_shift <= r_stg_synth_shift;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending    <= 1'b0;
      r_proto_err  <= 1'b0;
      // Starts high so an ack still asserted from before reset is not
      // mistaken for a fresh rise.
      r_ack_d      <= 1'b1;
      r_xfer_count <= '0;
    end else begin
      r_ack_d <= cpu_ack;
      // Commit is applied after launch so a coincident commit survives.
      if (w_launch) r_pending <= 1'b0;
      if (w_commit) r_pending <= 1'b1;
      if (w_errclr)        r_proto_err <= 1'b0;
      if (w_ack_rise_idle) r_proto_err <= 1'b1;
      if (w_complete) r_xfer_count <= r_xfer_count + 16'd1;
    end
  end

  always_comb begin
    rd_data = '0;
    case (rd_addr)
      ADDR_MOD_FCW:     rd_data = 32'(r_stg_mod_fcw);
      ADDR_MOD_SHIFT:   rd_data = 32'(r_stg_mod_shift);
      ADDR_NOTE_EN:     rd_data = 32'(r_stg_note_en);
      ADDR_SYNTH_SHIFT: rd_data = 32'(r_stg_synth_shift);
      ADDR_STATUS:      rd_data = {r_xfer_count, 12'b0, r_proto_err,
                                   r_pending, w_busy, w_req};
      default: begin
        for (int i = 0; i < N_VOICES; i++) begin
          if (rd_addr == 4'(i)) rd_data = 32'(r_stg_car[i]);
        end
      end
    endcase
  end

  assign cpu_carrier_fcws = r_snap_car;
  assign cpu_mod_fcw      = r_snap_mod_fcw;
  assign cpu_mod_shift    = r_snap_mod_shift;
  assign cpu_note_en      = r_snap_note_en;
  assign cpu_synth_shift  = r_snap_synth_shift;
  assign cpu_req          = w_req;
  assign busy             = w_busy;
  assign done             = w_done;
  assign proto_err        = r_proto_err;

endmodule
